// File: rtl/ime_pkg.sv
// Shared constants and types for the 4x4 integer full-search motion
// estimation stage.
//   WIN_W          reference window width/height (pixels)
//   BLK_W          current block width/height (pixels)
//   SAD_W / PIX_W  SAD accumulator and pixel widths
//   SR_MIN/SR_MAX  candidate top-left x/y range; the one-pixel border is
//                  kept free for the downstream fractional interpolation
package ime_pkg;
    localparam int WIN_W = 16;
    localparam int BLK_W = 4;
    localparam int SAD_W = 12;
    localparam int PIX_W = 8;

    localparam logic [3:0] SR_MIN = 4'd1;
    localparam logic [3:0] SR_MAX = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/ime_fullsearch_4x4_sad_row4.sv
// sad_row4: combinational sum of absolute differences across one 4-pixel row.
//   a, b  four 8-bit pixels each (reference row, current row)
//   sad   10-bit sum, 4*255 = 1020 at most
module sad_row4
    import ime_pkg::*;
(
    input  logic [BLK_W-1:0][PIX_W-1:0] a,
    input  logic [BLK_W-1:0][PIX_W-1:0] b,
    output logic [9:0]                  sad
);
    logic signed [PIX_W:0] d;
    logic        [PIX_W-1:0] ad;

    always_comb begin
        sad = '0;
        d   = '0;
        ad  = '0;
        for (int k = 0; k < BLK_W; k++) begin
            // Zero-extended operands, so the 9-bit signed difference never wraps.
            d   = $signed({1'b0, a[k]}) - $signed({1'b0, b[k]});
            ad  = d[PIX_W] ? PIX_W'(-d) : d[PIX_W-1:0];
            sad = sad + {2'b00, ad};
        end
    end
endmodule

// File: rtl/ime_fullsearch_4x4.sv
// ime_fullsearch_4x4: exhaustive integer-pel SAD search of a 4x4 block over
// a 16x16 reference window, candidates x,y in [SR_MIN, SR_MAX].
//   clk, rst              clock, synchronous active-high reset
//   start                 begin search (only honoured in IDLE)
//   ref_we/addr/data      reference window write port (IDLE only)
//   cur_we/addr/data      current block write port (IDLE only)
//   busy                  search running
//   done                  one-cycle pulse, best_pos/best_sad valid
//   best_pos, best_sad    winning top-left index (y*16+x) and its SAD
// Build option: IME_EARLY_TERM_EN abandons a candidate as soon as its
// partial SAD reaches the running best; results are unchanged.
module ime_fullsearch_4x4
    import ime_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ref_we,
    input  logic [7:0]       ref_addr,
    input  logic [PIX_W-1:0] ref_data,
    input  logic             cur_we,
    input  logic [3:0]       cur_addr,
    input  logic [PIX_W-1:0] cur_data,
    output logic             busy,
    output logic             done,
    output logic [7:0]       best_pos,
    output logic [SAD_W-1:0] best_sad
);
    logic [PIX_W-1:0] ref_mem [WIN_W*WIN_W];
    logic [PIX_W-1:0] cur_mem [BLK_W*BLK_W];

    state_t           state;
    logic [3:0]       cx, cy;
    logic [1:0]       row;
    logic [SAD_W-1:0] acc, run_best;
    logic [7:0]       run_pos;
    logic             best_vld;

    logic [BLK_W-1:0][PIX_W-1:0] ref_row, cur_row;
    logic [9:0]       row_sad;
    logic [3:0]       ry;
    logic [SAD_W-1:0] acc_nxt;
    logic             calc_end, upd, last_cand;

    // Arrays are not reset; they survive rst so a search can be rerun.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (ref_we) ref_mem[ref_addr] <= ref_data;
            if (cur_we) cur_mem[cur_addr] <= cur_data;
        end
    end

    assign ry = cy + {2'b00, row};

    for (genvar k = 0; k < BLK_W; k++) begin : g_row
        assign ref_row[k] = ref_mem[{ry, cx + 4'(k)}];
        assign cur_row[k] = cur_mem[{row, 2'(k)}];
    end

    sad_row4 u_sad (.a(ref_row), .b(cur_row), .sad(row_sad));

    assign acc_nxt   = acc + {{(SAD_W-10){1'b0}}, row_sad};
    assign upd       = !best_vld || (acc < run_best);
    assign last_cand = (cx == SR_MAX) && (cy == SR_MAX);

`ifdef IME_EARLY_TERM_EN
    // Once the partial sum ties the best, strict less-than can no longer win.
    assign calc_end = (row == 2'd3) || (best_vld && (acc_nxt >= run_best));
`else
    assign calc_end = (row == 2'd3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            best_pos <= '0;
            best_sad <= '0;
            cx       <= SR_MIN;
            cy       <= SR_MIN;
            row      <= '0;
            acc      <= '0;
            run_best <= '1;
            run_pos  <= '0;
            best_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= CALC;
                    cx       <= SR_MIN;
                    cy       <= SR_MIN;
                    row      <= '0;
                    acc      <= '0;
                    run_best <= '1;
                    best_vld <= 1'b0;
                    busy     <= 1'b1;
                end
                CALC: begin
                    acc <= acc_nxt;
                    row <= row + 2'd1;
                    if (calc_end) state <= CMP;
                end
                CMP: begin
                    if (upd) begin
                        run_best <= acc;
                        run_pos  <= {cy, cx};
                        best_vld <= 1'b1;
                    end
                    acc <= '0;
                    row <= '0;
                    if (last_cand) begin
                        // Fold in the last candidate's verdict directly.
                        best_pos <= upd ? {cy, cx} : run_pos;
                        best_sad <= upd ? acc : run_best;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        if (cx == SR_MAX) begin
                            cx <= SR_MIN;
                            cy <= cy + 4'd1;
                        end else begin
                            cx <= cx + 4'd1;
                        end
                        state <= CALC;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ime_fullsearch_4x4.sv
module tb_ime_fullsearch_4x4;
    logic        clk = 1'b0;
    logic        rst, start, ref_we, cur_we;
    logic [7:0]  ref_addr, ref_data, cur_data;
    logic [3:0]  cur_addr;
    logic        busy, done;
    logic [7:0]  best_pos;
    logic [11:0] best_sad;

    ime_fullsearch_4x4 dut (
        .clk(clk), .rst(rst), .start(start),
        .ref_we(ref_we), .ref_addr(ref_addr), .ref_data(ref_data),
        .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
        .busy(busy), .done(done), .best_pos(best_pos), .best_sad(best_sad)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [7:0] m_ref [256];
    logic [7:0] m_cur [16];

`ifdef IME_EARLY_TERM_EN
    localparam int LAT_FLAT = 245;
`else
    localparam int LAT_FLAT = 605;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: brute-force SAD over every candidate in raster order.
    task automatic model(output int bp, output int bs);
        int s, a;
        bs = -1; bp = 0;
        for (int y = 1; y <= 11; y++)
            for (int x = 1; x <= 11; x++) begin
                s = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        a = int'(m_ref[(y+r)*16 + x + c]) - int'(m_cur[r*4 + c]);
                        s += (a < 0) ? -a : a;
                    end
                if (bs < 0 || s < bs) begin bs = s; bp = y*16 + x; end
            end
    endtask

    task automatic load();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); ref_we = 1'b1; ref_addr = 8'(i); ref_data = m_ref[i];
        end
        @(negedge clk); ref_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); cur_we = 1'b1; cur_addr = 4'(i); cur_data = m_cur[i];
        end
        @(negedge clk); cur_we = 1'b0;
    endtask

    // dist_at: cycle at which start and a ref write are pulsed mid-search.
    // rst_at: cycle at which reset aborts the search (-1 = none).
    task automatic run(input int dist_at, input int rst_at, output int cyc);
        bit got, seen;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        cyc = 0; got = 0;
        while (cyc < 2000) begin
            if (cyc == dist_at) begin
                start = 1'b1; ref_we = 1'b1; ref_addr = 8'd17; ref_data = 8'hAA;
            end
            @(posedge clk); #1; cyc++;
            start = 1'b0; ref_we = 1'b0;
            if (rst_at >= 0 && cyc == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1; rst = 1'b0;
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_best_pos", int'(best_pos), 0);
                chk("rst_best_sad", int'(best_sad), 0);
                seen = 0;
                repeat (700) begin @(posedge clk); #1; if (done) seen = 1; end
                chk("no_done_after_rst", int'(seen), 0);
                return;
            end
            if (done) begin got = 1; break; end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic search_and_check(input string tag, input int dist_at, input int exp_lat);
        int cyc, ep, es;
        model(ep, es);
        run(dist_at, -1, cyc);
        if (exp_lat > 0) chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_pos"}, int'(best_pos), ep);
        chk({tag, "_sad"}, int'(best_sad), es);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, int'(done), 0);
        chk({tag, "_hold_pos"}, int'(best_pos), ep);
    endtask

    initial begin
        int cyc, px, py, lat;
        rst = 1'b1; start = 1'b0; ref_we = 1'b0; cur_we = 1'b0;
        ref_addr = '0; ref_data = '0; cur_addr = '0; cur_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", int'(busy), 0);
        chk("init_done", int'(done), 0);
        chk("init_best_pos", int'(best_pos), 0);
        chk("init_best_sad", int'(best_sad), 0);
        rst = 1'b0;

        // Flat data: every candidate ties at 0, first (1,1)=17 wins.
        foreach (m_ref[i]) m_ref[i] = 8'h10;
        foreach (m_cur[i]) m_cur[i] = 8'h10;
        load();
        search_and_check("flat", -1, LAT_FLAT);
        chk("flat_pos_const", int'(best_pos), 17);

        // Single exact match at x=7,y=5 -> 87.
        foreach (m_ref[i]) m_ref[i] = 8'h00;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m_ref[(5+r)*16 + 7 + c] = 8'h80;
        foreach (m_cur[i]) m_cur[i] = 8'h80;
        load();
        search_and_check("match", -1, 0);
        chk("match_pos_const", int'(best_pos), 87);

        // Maximal SAD everywhere: 16*255.
        foreach (m_ref[i]) m_ref[i] = 8'h00;
        foreach (m_cur[i]) m_cur[i] = 8'hFF;
        load();
        search_and_check("maxsad", -1, 0);
        chk("maxsad_const", int'(best_sad), 4080);

        // Start and ref write mid-search must be ignored.
        foreach (m_ref[i]) m_ref[i] = 8'h10;
        foreach (m_cur[i]) m_cur[i] = 8'h10;
        load();
        search_and_check("disturb", 100, LAT_FLAT);
        search_and_check("disturb_rerun", -1, LAT_FLAT);

        // Reset mid-search, then arrays must still be intact.
        run(-1, 200, cyc);
        search_and_check("after_rst", -1, LAT_FLAT);

`ifdef IME_EARLY_TERM_EN
        lat = 0;
`else
        lat = 605;
`endif
        // Random windows.
        for (int t = 0; t < 4; t++) begin
            foreach (m_ref[i]) m_ref[i] = 8'($urandom);
            foreach (m_cur[i]) m_cur[i] = 8'($urandom);
            load();
            search_and_check($sformatf("rnd%0d", t), -1, lat);
        end
        // Random windows with the block planted at a random position.
        for (int t = 0; t < 3; t++) begin
            foreach (m_ref[i]) m_ref[i] = 8'($urandom_range(0, 63));
            foreach (m_cur[i]) m_cur[i] = 8'($urandom_range(128, 255));
            px = $urandom_range(1, 11); py = $urandom_range(1, 11);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) m_ref[(py+r)*16 + px + c] = m_cur[r*4 + c];
            load();
            search_and_check($sformatf("plant%0d", t), -1, lat);
            chk($sformatf("plant%0d_pos_direct", t), int'(best_pos), py*16 + px);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
